evha_ptw_dmem_arb: RTL and testbench
====================================

Name: evha_ptw_dmem_arb

Overview:
Responder-side block for the MMU page-table-walker memory port. It accepts PTW requests (req/cmd/addr in, rdy/ldata/exc out) and LSU requests, and arbitrates both onto the single core DMEM port. It tracks the owner of each outstanding transaction and routes each DMEM response back to the correct requester, converting the SCR1 req/ack/resp protocol into the PTW's single-pulse rdy/exc interface.

Parameters:
OUTSTD_DEPTH, 2, max outstanding DMEM transactions tracked in the owner FIFO (power of 2, >=1)
PTW_PRIO, 1, 1 = PTW wins simultaneous requests; 0 = LSU wins

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
mmu2dmem_req_i  in  1  PTW request
mmu2dmem_cmd_i  in  type_scr1_mem_cmd_e  PTW command (RD/WR)
mmu2dmem_addr_i  in  XLEN  PTW PTE physical address
dmem2mmu_rdy_o  out  1  PTW accepted-and-completed pulse
dmem2mmu_ldata_o  out  XLEN  PTE data, valid with rdy
dmem2mmu_exc_o  out  1  access error, valid with rdy
lsu2arb_req_i  in  1  LSU request
lsu2arb_cmd_i  in  type_scr1_mem_cmd_e  LSU command
lsu2arb_width_i  in  type_scr1_mem_width_e  LSU access width
lsu2arb_addr_i  in  XLEN  LSU address
lsu2arb_wdata_i  in  XLEN  LSU write data
arb2lsu_req_ack_o  out  1  LSU request accepted
arb2lsu_rdata_o  out  XLEN  LSU read data
arb2lsu_resp_o  out  type_scr1_mem_resp_e  LSU response
arb2dmem_req_o  out  1  DMEM request
arb2dmem_cmd_o  out  type_scr1_mem_cmd_e  DMEM command
arb2dmem_width_o  out  type_scr1_mem_width_e  DMEM width
arb2dmem_addr_o  out  XLEN  DMEM address
arb2dmem_wdata_o  out  XLEN  DMEM write data
dmem2arb_req_ack_i  in  1  DMEM accepted request
dmem2arb_rdata_i  in  XLEN  DMEM read data
dmem2arb_resp_i  in  type_scr1_mem_resp_e  DMEM response
arb_unexp_resp_o  out  1  pulse: response received with no outstanding owner

Behaviour:
- Reset (async): owner FIFO empty, lock cleared, all req/ack/rdy/exc/pulse outputs 0, resp outputs SCR1_MEM_RESP_NOTRDY, data outputs 0. Any in-flight responses after reset release are treated as unexpected.
- Request path (0-cycle, combinational): arb2dmem_req_o = selected source req & ~fifo_full. Nothing is forwarded while the FIFO is full.
- Selection: if lock is set, select the locked source. Otherwise PTW_PRIO decides between simultaneous requests; a single requester wins.
- Lock: set when arb2dmem_req_o=1 and dmem2arb_req_ack_i=0; holds the source until ack. No source switch is allowed mid-handshake.
- PTW forwarding: width forced to SCR1_MEM_WIDTH_DWORD, wdata forced to 0, cmd/addr passed through.
- LSU forwarding: all fields passed through. arb2lsu_req_ack_o = dmem2arb_req_ack_i & LSU selected & ~fifo_full.
- Push: owner ID (0=LSU, 1=PTW) is pushed on arb2dmem_req_o & dmem2arb_req_ack_i.
- Pop: on dmem2arb_resp_i != NOTRDY with the FIFO non-empty, pop the head owner. Routing is combinational in the same cycle:
  - PTW owner: dmem2mmu_rdy_o=1, ldata=rdata, exc=(resp==RDY_ER).
  - LSU owner: arb2lsu_resp_o=resp, arb2lsu_rdata_o=rdata.
  - The non-owning side sees rdy=0 / resp NOTRDY.
- Simultaneous push and pop: both take effect, count unchanged. Full with pop: the push still waits until the next cycle, so there is no resp->req combinational path.
- Response with the FIFO empty: dropped; arb_unexp_resp_o=1 for one cycle; no pointer change.
- Pointers wrap modulo OUTSTD_DEPTH. Count width is clog2(OUTSTD_DEPTH)+1.
- Responses return in order; DMEM is in-order.

Optional Feature:
EVHA_PTW_ARB_PERF_EN: when defined, adds 64-bit outputs arb_ptw_acc_cnt_o and arb_lsu_stall_cnt_o, reset to 0.
- arb_ptw_acc_cnt_o increments on each PTW push.
- arb_lsu_stall_cnt_o increments each cycle lsu2arb_req_i=1 and arb2lsu_req_ack_o=0.
- Both saturate at all-ones.
Without the macro, neither the ports nor the counters exist.

Test Plan:
- PTW RD addr 0x8000_1008, ack same cycle, resp RDY_OK rdata 0x2000_00CF two cycles later -> arb2dmem width DWORD, dmem2mmu_rdy_o=1 with ldata 0x2000_00CF, exc=0; LSU resp stays NOTRDY.
- PTW and LSU request in the same cycle, PTW_PRIO=1 -> PTW forwarded first; LSU acked next cycle; responses OK then ER -> PTW rdy exc=0, then LSU resp=RDY_ER.
- LSU request with ack held low 3 cycles while PTW asserts in cycle 2 -> DMEM fields stay LSU's until ack (lock); PTW forwarded afterwards.
- OUTSTD_DEPTH=2: two acked requests, no responses -> third request gets arb2dmem_req_o=0 until the first response pops; FIFO order is preserved.
- dmem2arb_resp_i=RDY_OK with the FIFO empty -> arb_unexp_resp_o one-cycle pulse; neither dmem2mmu_rdy_o nor LSU resp asserted.
- rst_n asserted with 2 outstanding, released, then a response arrives -> arb_unexp_resp_o=1; all outputs held at reset values during reset.

Source files
------------

// File: rtl/evha_ptw_dmem_arb.sv
// evha_ptw_dmem_arb: shares the core DMEM port between the MMU page-table
// walker and the LSU. It tracks the owner of every accepted transaction in
// an in-order FIFO and routes each DMEM response back to its owner.
// Optional build macro EVHA_PTW_ARB_PERF_EN adds saturating 64-bit counters
// for PTW accesses and LSU stall cycles.

package evha_ptw_dmem_arb_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_DWORD = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module evha_ptw_dmem_arb
    import evha_ptw_dmem_arb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int OUTSTD_DEPTH = 2,
    parameter bit PTW_PRIO     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    // PTW side
    input  logic            mmu2dmem_req_i,
    input  logic            mmu2dmem_cmd_i,
    input  logic [XLEN-1:0] mmu2dmem_addr_i,
    output logic            dmem2mmu_rdy_o,
    output logic [XLEN-1:0] dmem2mmu_ldata_o,
    output logic            dmem2mmu_exc_o,
    // LSU side
    input  logic            lsu2arb_req_i,
    input  logic            lsu2arb_cmd_i,
    input  logic [1:0]      lsu2arb_width_i,
    input  logic [XLEN-1:0] lsu2arb_addr_i,
    input  logic [XLEN-1:0] lsu2arb_wdata_i,
    output logic            arb2lsu_req_ack_o,
    output logic [XLEN-1:0] arb2lsu_rdata_o,
    output logic [1:0]      arb2lsu_resp_o,
    // DMEM side
    output logic            arb2dmem_req_o,
    output logic            arb2dmem_cmd_o,
    output logic [1:0]      arb2dmem_width_o,
    output logic [XLEN-1:0] arb2dmem_addr_o,
    output logic [XLEN-1:0] arb2dmem_wdata_o,
    input  logic            dmem2arb_req_ack_i,
    input  logic [XLEN-1:0] dmem2arb_rdata_i,
    input  logic [1:0]      dmem2arb_resp_i,
`ifdef EVHA_PTW_ARB_PERF_EN
    output logic [63:0]     arb_ptw_acc_cnt_o,
    output logic [63:0]     arb_lsu_stall_cnt_o,
`endif
    output logic            arb_unexp_resp_o
);

    localparam int PTR_W = (OUTSTD_DEPTH > 1) ? $clog2(OUTSTD_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTSTD_DEPTH) + 1;

    // Owner encoding stored in the FIFO
    localparam logic OWNER_LSU = 1'b0;
    localparam logic OWNER_PTW = 1'b1;

    logic             lock_q;
    logic             lock_src_q;
    logic             src_ptw;
    logic             sel_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             resp_vld;
    logic             head_owner;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q [OUTSTD_DEPTH];

    assign fifo_full  = (cnt_q == CNT_W'(OUTSTD_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign resp_vld   = (dmem2arb_resp_i != SCR1_MEM_RESP_NOTRDY);
    assign head_owner = owner_q[rd_ptr_q];
    assign pop        = resp_vld & ~fifo_empty;
    assign push       = arb2dmem_req_o & dmem2arb_req_ack_i;

    // Source selection: a pending handshake keeps its source, otherwise priority
    always_comb begin
        src_ptw = 1'b0;
        if (lock_q) begin
            src_ptw = lock_src_q;
        end else if (mmu2dmem_req_i && lsu2arb_req_i) begin
            src_ptw = PTW_PRIO;
        end else begin
            src_ptw = mmu2dmem_req_i;
        end
        sel_req = src_ptw ? mmu2dmem_req_i : lsu2arb_req_i;
    end

    // DMEM request forwarding; fields are zero while no request is issued
    always_comb begin
        arb2dmem_req_o    = sel_req & ~fifo_full;
        arb2dmem_cmd_o    = SCR1_MEM_CMD_RD;
        arb2dmem_width_o  = SCR1_MEM_WIDTH_BYTE;
        arb2dmem_addr_o   = '0;
        arb2dmem_wdata_o  = '0;
        arb2lsu_req_ack_o = 1'b0;
        if (arb2dmem_req_o) begin
            if (src_ptw) begin
                arb2dmem_cmd_o   = mmu2dmem_cmd_i;
                arb2dmem_width_o = SCR1_MEM_WIDTH_DWORD;
                arb2dmem_addr_o  = mmu2dmem_addr_i;
            end else begin
                arb2dmem_cmd_o    = lsu2arb_cmd_i;
                arb2dmem_width_o  = lsu2arb_width_i;
                arb2dmem_addr_o   = lsu2arb_addr_i;
                arb2dmem_wdata_o  = lsu2arb_wdata_i;
                arb2lsu_req_ack_o = dmem2arb_req_ack_i;
            end
        end
    end

    // Response routing to the owner at the FIFO head
    always_comb begin
        dmem2mmu_rdy_o   = 1'b0;
        dmem2mmu_ldata_o = '0;
        dmem2mmu_exc_o   = 1'b0;
        arb2lsu_resp_o   = SCR1_MEM_RESP_NOTRDY;
        arb2lsu_rdata_o  = '0;
        arb_unexp_resp_o = resp_vld & fifo_empty;
        if (pop) begin
            if (head_owner == OWNER_PTW) begin
                dmem2mmu_rdy_o   = 1'b1;
                dmem2mmu_ldata_o = dmem2arb_rdata_i;
                dmem2mmu_exc_o   = (dmem2arb_resp_i == SCR1_MEM_RESP_RDY_ER);
            end else begin
                arb2lsu_resp_o  = dmem2arb_resp_i;
                arb2lsu_rdata_o = dmem2arb_rdata_i;
            end
        end
    end

    // Lock holds the source while a request waits for its ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_src_q <= OWNER_LSU;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            lock_q     <= arb2dmem_req_o & ~dmem2arb_req_ack_i;
            lock_src_q <= src_ptw;
        end
    end

    // Owner FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTD_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTD_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Owner storage written on every accepted request
    // NOTE: the storage is not reset; entries are only read when the count
    // says they were written, so reset pointers alone keep it consistent.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wr_ptr_q] <= src_ptw;
        end
    end

`ifdef EVHA_PTW_ARB_PERF_EN
    // Saturating PTW access and LSU stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_ptw_acc_cnt_o   <= '0;
            arb_lsu_stall_cnt_o <= '0;
        end else begin
            if (push && src_ptw && (arb_ptw_acc_cnt_o != '1)) begin
                arb_ptw_acc_cnt_o <= arb_ptw_acc_cnt_o + 1'b1;
            end
            if (lsu2arb_req_i && !arb2lsu_req_ack_o && (arb_lsu_stall_cnt_o != '1)) begin
                arb_lsu_stall_cnt_o <= arb_lsu_stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_evha_ptw_dmem_arb.sv
// Directed bench for evha_ptw_dmem_arb (XLEN=64, OUTSTD_DEPTH=2, PTW_PRIO=1).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
module tb_evha_ptw_dmem_arb;
    import evha_ptw_dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ptw_req, ptw_cmd;
    logic [63:0] ptw_addr;
    logic        mmu_rdy, mmu_exc;
    logic [63:0] mmu_ldata;
    logic        lsu_req, lsu_cmd;
    logic [1:0]  lsu_width;
    logic [63:0] lsu_addr, lsu_wdata;
    logic        lsu_ack;
    logic [63:0] lsu_rdata;
    logic [1:0]  lsu_resp;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        unexp;
`ifdef EVHA_PTW_ARB_PERF_EN
    logic [63:0] ptw_acc_cnt, lsu_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    evha_ptw_dmem_arb #(.XLEN(64), .OUTSTD_DEPTH(2), .PTW_PRIO(1'b1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mmu2dmem_req_i     (ptw_req),
        .mmu2dmem_cmd_i     (ptw_cmd),
        .mmu2dmem_addr_i    (ptw_addr),
        .dmem2mmu_rdy_o     (mmu_rdy),
        .dmem2mmu_ldata_o   (mmu_ldata),
        .dmem2mmu_exc_o     (mmu_exc),
        .lsu2arb_req_i      (lsu_req),
        .lsu2arb_cmd_i      (lsu_cmd),
        .lsu2arb_width_i    (lsu_width),
        .lsu2arb_addr_i     (lsu_addr),
        .lsu2arb_wdata_i    (lsu_wdata),
        .arb2lsu_req_ack_o  (lsu_ack),
        .arb2lsu_rdata_o    (lsu_rdata),
        .arb2lsu_resp_o     (lsu_resp),
        .arb2dmem_req_o     (dmem_req),
        .arb2dmem_cmd_o     (dmem_cmd),
        .arb2dmem_width_o   (dmem_width),
        .arb2dmem_addr_o    (dmem_addr),
        .arb2dmem_wdata_o   (dmem_wdata),
        .dmem2arb_req_ack_i (dmem_ack),
        .dmem2arb_rdata_i   (dmem_rdata),
        .dmem2arb_resp_i    (dmem_resp),
`ifdef EVHA_PTW_ARB_PERF_EN
        .arb_ptw_acc_cnt_o  (ptw_acc_cnt),
        .arb_lsu_stall_cnt_o(lsu_stall_cnt),
`endif
        .arb_unexp_resp_o   (unexp)
    );

    task automatic idle();
        ptw_req = 1'b0; ptw_cmd = SCR1_MEM_CMD_RD; ptw_addr = '0;
        lsu_req = 1'b0; lsu_cmd = SCR1_MEM_CMD_RD; lsu_width = SCR1_MEM_WIDTH_BYTE;
        lsu_addr = '0; lsu_wdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; dmem_resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req got %0h exp 0", dmem_req); end
        n_checks++; if (mmu_rdy !== 1'b0 || mmu_exc !== 1'b0) begin n_fail++; $display("FAIL rst_mmu got rdy=%0h exc=%0h exp 0/0", mmu_rdy, mmu_exc); end
        n_checks++; if (lsu_ack !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ack got %0h exp 0", lsu_ack); end
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rst_lsu_resp got %0h exp 0", lsu_resp); end
        n_checks++; if (unexp !== 1'b0) begin n_fail++; $display("FAIL rst_unexp got %0h exp 0", unexp); end
        n_checks++; if (mmu_ldata !== 64'h0 || lsu_rdata !== 64'h0 || dmem_addr !== 64'h0) begin n_fail++; $display("FAIL rst_data got ldata=%0h rdata=%0h addr=%0h exp 0", mmu_ldata, lsu_rdata, dmem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ptw_read();
        ptw_req = 1'b1; ptw_cmd = SCR1_MEM_CMD_RD; ptw_addr = 64'h8000_1008;
        lsu_wdata = 64'h5555_AAAA; dmem_ack = 1'b1;
        settle();
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL ptw_req_fwd got %0h exp 1", dmem_req); end
        n_checks++; if (dmem_addr !== 64'h8000_1008) begin n_fail++; $display("FAIL ptw_addr got %0h exp 80001008", dmem_addr); end
        n_checks++; if (dmem_width !== SCR1_MEM_WIDTH_DWORD) begin n_fail++; $display("FAIL ptw_width got %0h exp 3", dmem_width); end
        n_checks++; if (dmem_wdata !== 64'h0 || dmem_cmd !== SCR1_MEM_CMD_RD) begin n_fail++; $display("FAIL ptw_wdata_cmd got %0h/%0h exp 0/0", dmem_wdata, dmem_cmd); end
        n_checks++; if (lsu_ack !== 1'b0) begin n_fail++; $display("FAIL ptw_lsu_ack got %0h exp 0", lsu_ack); end
        tick();
        idle();
        settle();
        n_checks++; if (mmu_rdy !== 1'b0) begin n_fail++; $display("FAIL ptw_early_rdy got %0h exp 0", mmu_rdy); end
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h2000_00CF;
        settle();
        n_checks++; if (mmu_rdy !== 1'b1) begin n_fail++; $display("FAIL ptw_rdy got %0h exp 1", mmu_rdy); end
        n_checks++; if (mmu_ldata !== 64'h2000_00CF) begin n_fail++; $display("FAIL ptw_ldata got %0h exp 200000cf", mmu_ldata); end
        n_checks++; if (mmu_exc !== 1'b0) begin n_fail++; $display("FAIL ptw_exc got %0h exp 0", mmu_exc); end
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_NOTRDY || unexp !== 1'b0) begin n_fail++; $display("FAIL ptw_lsu_side got resp=%0h unexp=%0h exp 0/0", lsu_resp, unexp); end
        tick();
        idle();
        settle();
        n_checks++; if (mmu_rdy !== 1'b0) begin n_fail++; $display("FAIL ptw_rdy_pulse got %0h exp 0", mmu_rdy); end
        tick();
    endtask

    task automatic test_priority();
        ptw_req = 1'b1; ptw_addr = 64'h100;
        lsu_req = 1'b1; lsu_cmd = SCR1_MEM_CMD_WR; lsu_width = SCR1_MEM_WIDTH_WORD;
        lsu_addr = 64'h200; lsu_wdata = 64'hDEAD; dmem_ack = 1'b1;
        settle();
        n_checks++; if (dmem_addr !== 64'h100 || dmem_width !== SCR1_MEM_WIDTH_DWORD) begin n_fail++; $display("FAIL prio_ptw_first got addr=%0h w=%0h exp 100/3", dmem_addr, dmem_width); end
        n_checks++; if (lsu_ack !== 1'b0) begin n_fail++; $display("FAIL prio_lsu_ack0 got %0h exp 0", lsu_ack); end
        tick();
        ptw_req = 1'b0;
        settle();
        n_checks++; if (dmem_addr !== 64'h200 || dmem_cmd !== SCR1_MEM_CMD_WR || dmem_width !== SCR1_MEM_WIDTH_WORD || dmem_wdata !== 64'hDEAD) begin n_fail++; $display("FAIL prio_lsu_fields got addr=%0h cmd=%0h w=%0h wd=%0h exp 200/1/2/dead", dmem_addr, dmem_cmd, dmem_width, dmem_wdata); end
        n_checks++; if (lsu_ack !== 1'b1) begin n_fail++; $display("FAIL prio_lsu_ack1 got %0h exp 1", lsu_ack); end
        tick();
        idle();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h11;
        settle();
        n_checks++; if (mmu_rdy !== 1'b1 || mmu_exc !== 1'b0 || lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL prio_resp1 got rdy=%0h exc=%0h lresp=%0h exp 1/0/0", mmu_rdy, mmu_exc, lsu_resp); end
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_ER; dmem_rdata = 64'h22;
        settle();
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_RDY_ER || lsu_rdata !== 64'h22 || mmu_rdy !== 1'b0) begin n_fail++; $display("FAIL prio_resp2 got lresp=%0h rdata=%0h rdy=%0h exp 2/22/0", lsu_resp, lsu_rdata, mmu_rdy); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_lock();
        lsu_req = 1'b1; lsu_addr = 64'h300; lsu_width = SCR1_MEM_WIDTH_HWORD;
        settle();
        n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h300 || lsu_ack !== 1'b0) begin n_fail++; $display("FAIL lock_c1 got req=%0h addr=%0h ack=%0h exp 1/300/0", dmem_req, dmem_addr, lsu_ack); end
        tick();
        ptw_req = 1'b1; ptw_addr = 64'h400;
        settle();
        n_checks++; if (dmem_addr !== 64'h300 || dmem_width !== SCR1_MEM_WIDTH_HWORD) begin n_fail++; $display("FAIL lock_hold2 got addr=%0h w=%0h exp 300/1", dmem_addr, dmem_width); end
        tick();
        settle();
        n_checks++; if (dmem_addr !== 64'h300) begin n_fail++; $display("FAIL lock_hold3 got addr=%0h exp 300", dmem_addr); end
        tick();
        dmem_ack = 1'b1;
        settle();
        n_checks++; if (dmem_addr !== 64'h300 || lsu_ack !== 1'b1) begin n_fail++; $display("FAIL lock_ack got addr=%0h ack=%0h exp 300/1", dmem_addr, lsu_ack); end
        tick();
        lsu_req = 1'b0;
        settle();
        n_checks++; if (dmem_addr !== 64'h400 || dmem_width !== SCR1_MEM_WIDTH_DWORD || lsu_ack !== 1'b0) begin n_fail++; $display("FAIL lock_ptw_after got addr=%0h w=%0h ack=%0h exp 400/3/0", dmem_addr, dmem_width, lsu_ack); end
        tick();
        idle();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h33;
        settle();
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_RDY_OK || mmu_rdy !== 1'b0) begin n_fail++; $display("FAIL lock_drain1 got lresp=%0h rdy=%0h exp 1/0", lsu_resp, mmu_rdy); end
        tick();
        settle();
        n_checks++; if (mmu_rdy !== 1'b1 || mmu_ldata !== 64'h33) begin n_fail++; $display("FAIL lock_drain2 got rdy=%0h ldata=%0h exp 1/33", mmu_rdy, mmu_ldata); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_full();
        lsu_req = 1'b1; lsu_addr = 64'h500; dmem_ack = 1'b1;
        tick();
        lsu_req = 1'b0; ptw_req = 1'b1; ptw_addr = 64'h600;
        tick();
        ptw_req = 1'b0; lsu_req = 1'b1; lsu_addr = 64'h700;
        settle();
        n_checks++; if (dmem_req !== 1'b0 || lsu_ack !== 1'b0) begin n_fail++; $display("FAIL full_block got req=%0h ack=%0h exp 0/0", dmem_req, lsu_ack); end
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h44;
        settle();
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_noreq got %0h exp 0", dmem_req); end
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_RDY_OK || lsu_rdata !== 64'h44 || mmu_rdy !== 1'b0) begin n_fail++; $display("FAIL full_order1 got lresp=%0h rdata=%0h rdy=%0h exp 1/44/0", lsu_resp, lsu_rdata, mmu_rdy); end
        tick();
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        settle();
        n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h700 || lsu_ack !== 1'b1) begin n_fail++; $display("FAIL full_resume got req=%0h addr=%0h ack=%0h exp 1/700/1", dmem_req, dmem_addr, lsu_ack); end
        tick();
        idle();
        dmem_resp = SCR1_MEM_RESP_RDY_ER; dmem_rdata = 64'h55;
        settle();
        n_checks++; if (mmu_rdy !== 1'b1 || mmu_exc !== 1'b1 || mmu_ldata !== 64'h55) begin n_fail++; $display("FAIL full_order2 got rdy=%0h exc=%0h ldata=%0h exp 1/1/55", mmu_rdy, mmu_exc, mmu_ldata); end
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h66;
        settle();
        n_checks++; if (lsu_resp !== SCR1_MEM_RESP_RDY_OK || lsu_rdata !== 64'h66 || unexp !== 1'b0) begin n_fail++; $display("FAIL full_order3 got lresp=%0h rdata=%0h unexp=%0h exp 1/66/0", lsu_resp, lsu_rdata, unexp); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_unexpected();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h77;
        settle();
        n_checks++; if (unexp !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse got %0h exp 1", unexp); end
        n_checks++; if (mmu_rdy !== 1'b0 || lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL unexp_route got rdy=%0h lresp=%0h exp 0/0", mmu_rdy, lsu_resp); end
        tick();
        idle();
        settle();
        n_checks++; if (unexp !== 1'b0) begin n_fail++; $display("FAIL unexp_clear got %0h exp 0", unexp); end
        tick();
    endtask

    task automatic test_reset_outstanding();
        lsu_req = 1'b1; lsu_addr = 64'h800; dmem_ack = 1'b1;
        tick();
        lsu_req = 1'b0; ptw_req = 1'b1; ptw_addr = 64'h900;
        tick();
        idle();
        rst_n = 1'b0;
        settle();
        n_checks++; if (dmem_req !== 1'b0 || mmu_rdy !== 1'b0 || lsu_ack !== 1'b0 || unexp !== 1'b0 || lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rst2_outputs got req=%0h rdy=%0h ack=%0h unexp=%0h lresp=%0h exp 0", dmem_req, mmu_rdy, lsu_ack, unexp, lsu_resp); end
        tick();
        rst_n = 1'b1;
        tick();
        dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 64'h88;
        settle();
        n_checks++; if (unexp !== 1'b1 || mmu_rdy !== 1'b0 || lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rst2_stale got unexp=%0h rdy=%0h lresp=%0h exp 1/0/0", unexp, mmu_rdy, lsu_resp); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_ptw_read();
        test_priority();
        test_lock();
        test_full();
        test_unexpected();
        test_reset_outstanding();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
